elastic_pipe: RTL and testbench

Parametrised multi-lane delay pipeline with valid/ready flow control, replacing fixed always-advancing register chains wherever a stage must be able to stall. Carries `LANES` lanes of `D_W`-bit data through `DEPTH` register stages. With no stall, latency is exactly `DEPTH` cycles. Under backpressure, bubbles collapse, so every stage holding a beat can be filled. Sits between systolic-array feeders/drainers and downstream consumers in the matrix-multiplication datapath.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/elastic_stage.sv | 40 ++++
 rtl/elastic_pipe.sv | 92 +++++++++
 tb/tb_elastic_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and helpers for the elastic pipeline: parameter defaults,
// occupancy counter sizing and lane packing offsets.
package pipe_pkg;

  localparam int D_W_DEF   = 8;
  localparam int LANES_DEF = 4;
  localparam int DEPTH_DEF = 10;

  // The counter must reach DEPTH itself, not DEPTH-1.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int lane_lo(input int lane, input int d_w);
    return lane * d_w;
  endfunction

endpackage

// File: rtl/elastic_stage.sv
// One register stage of the elastic pipe: holds a valid bit and a data word,
// and takes the upstream beat whenever it is empty or its successor advances.
module elastic_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_prev_vld,
  input  logic [W-1:0] i_prev_dat,
  input  logic         i_adv_next,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;
  logic         w_adv;

  assign w_adv = !r_vld || i_adv_next;

  // Flush drops the valid bit but leaves the data word as it was.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (w_adv) begin
      r_vld <= i_prev_vld;
      if (i_prev_vld) begin
        r_dat <= i_prev_dat;
      end
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/elastic_pipe.sv
// Multi-lane DEPTH-stage delay line with valid/ready handshaking; stalled
// stages let upstream bubbles collapse so every stage can hold a beat.
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [D_W*LANES-1:0]       in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [D_W*LANES-1:0]       out_data,
  output logic [occ_w(DEPTH)-1:0]    occupancy
);

  localparam int W  = D_W * LANES;
  localparam int OW = occ_w(DEPTH);

  logic [DEPTH-1:0] w_vld;
  logic [W-1:0]     w_dat [DEPTH];
  logic [DEPTH:0]   w_adv;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [OW-1:0]    r_occ;

  // Advance ripples back from the output: a stage moves if it is empty or
  // the stage ahead of it moves, so in_ready sees out_ready combinationally.
  always_comb begin
    logic [DEPTH:0] adv_t;
    adv_t        = '0;
    adv_t[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv_t[k] = !w_vld[k] || adv_t[k+1];
    end
    w_adv = adv_t;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      elastic_stage #(.W(W)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (flush),
        .i_prev_vld (in_valid),
        .i_prev_dat (in_data),
        .i_adv_next (w_adv[k+1]),
        .o_vld      (w_vld[k]),
        .o_dat      (w_dat[k])
      );
    end else begin : g_rest
      elastic_stage #(.W(W)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (flush),
        .i_prev_vld (w_vld[k-1]),
        .i_prev_dat (w_dat[k-1]),
        .i_adv_next (w_adv[k+1]),
        .o_vld      (w_vld[k]),
        .o_dat      (w_dat[k])
      );
    end
  end

  assign in_ready  = w_adv[0] && !flush;
  assign out_valid = w_vld[DEPTH-1] && !flush;
  assign out_data  = w_dat[DEPTH-1];

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Tracks the popcount of the valid bits without summing them each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_occ <= r_occ + OW'(1);
    end else if (!w_in_fire && w_out_fire) begin
      r_occ <= r_occ - OW'(1);
    end
  end

  assign occupancy = r_occ;

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: a 10-deep 4x8 instance and a 1-deep 1x16 instance,
// both tracked every cycle by a queue-of-beats reference model.
module tb_elastic_pipe;
  import pipe_pkg::*;

  localparam int DA = 10;
  localparam int WA = 32;
  localparam int DB = 1;
  localparam int WB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WA-1:0]          in_data, out_data;
  logic [occ_w(DA)-1:0]   occupancy;
  logic                   s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [WB-1:0]          s_in_data, s_out_data;
  logic [occ_w(DB)-1:0]   s_occ;

  elastic_pipe #(.D_W(8), .LANES(4), .DEPTH(DA)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  elastic_pipe #(.D_W(16), .LANES(1), .DEPTH(DB)) u_sweep (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occ)
  );

  typedef struct { logic [31:0] d; int pos; } beat_t;
  typedef beat_t beat_q_t[$];

  typedef struct {
    logic        iv;
    logic        ordy;
    logic [31:0] d;
    logic        e_irdy;
    logic        e_ovld;
    int          e_occ;
  } vec_t;

  beat_q_t     qa, qb;
  logic [31:0] lasta, lastb;
  int          checks = 0;
  int          errors = 0;
  logic        obs_irdy, obs_ovld;
  logic [31:0] obs_odata;
  int          obs_occ;
  vec_t        tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int k);
    logic [31:0] p;
    p = '0;
    for (int l = 0; l < 4; l++) p[lane_lo(l, 8) +: 8] = 8'(k + l);
    return p;
  endfunction

  // Each beat knows which stage it sits in; a beat moves one stage forward
  // when the slot ahead is free or the beat ahead moves too.
  task automatic m_step(inout beat_q_t q, inout logic [31:0] last, input int depth,
                        input logic fl, input logic iv, input logic ordy,
                        input logic [31:0] idat);
    beat_q_t nq;
    int      ahead_old;
    logic    ahead_mv, mv;
    beat_t   b;
    if (!fl) begin
      ahead_old = depth;
      ahead_mv  = ordy;
      for (int i = 0; i < q.size(); i++) begin
        b         = q[i];
        mv        = (b.pos + 1 < ahead_old) || ahead_mv;
        ahead_old = b.pos;
        ahead_mv  = mv;
        if (!(mv && b.pos == depth - 1)) begin
          if (mv) begin
            b.pos++;
            if (b.pos == depth - 1) last = b.d;
          end
          nq.push_back(b);
        end
      end
      if (iv && (ordy || q.size() < depth)) begin
        b.d   = idat;
        b.pos = 0;
        if (depth == 1) last = idat;
        nq.push_back(b);
      end
    end
    q = nq;
  endtask

  task automatic cyc();
    logic ea_irdy, ea_ovld, eb_irdy, eb_ovld;
    @(negedge clk);
    ea_irdy = !flush && (out_ready || qa.size() < DA);
    ea_ovld = 1'b0;
    if (!flush && qa.size() > 0) ea_ovld = (qa[0].pos == DA - 1);
    eb_irdy = !s_flush && (s_out_ready || qb.size() < DB);
    eb_ovld = 1'b0;
    if (!s_flush && qb.size() > 0) eb_ovld = (qb[0].pos == DB - 1);
    chk("a_in_ready", in_ready, ea_irdy);
    chk("a_out_valid", out_valid, ea_ovld);
    chk("a_occupancy", occupancy, qa.size());
    chk("a_out_data", out_data, lasta);
    chk("b_in_ready", s_in_ready, eb_irdy);
    chk("b_out_valid", s_out_valid, eb_ovld);
    chk("b_occupancy", s_occ, qb.size());
    chk("b_out_data", {16'h0, s_out_data}, lastb);
    obs_irdy  = in_ready;
    obs_ovld  = out_valid;
    obs_odata = out_data;
    obs_occ   = int'(occupancy);
    @(posedge clk);
    m_step(qa, lasta, DA, flush, in_valid, out_ready, in_data);
    m_step(qb, lastb, DB, s_flush, s_in_valid, s_out_ready, {16'h0, s_in_data});
    #1;
  endtask

  initial begin
    int sent, got, acc, first_acc, first_ov, lat;
    tbl = '{
      '{1'b1, 1'b0, 32'h67666564, 1'b1, 1'b0, 0},
      '{1'b1, 1'b0, 32'h68676665, 1'b1, 1'b0, 1},
      '{1'b1, 1'b0, 32'h69686766, 1'b1, 1'b0, 2},
      '{1'b1, 1'b0, 32'h6A696867, 1'b1, 1'b0, 3},
      '{1'b1, 1'b0, 32'h6B6A6968, 1'b1, 1'b0, 4},
      '{1'b1, 1'b0, 32'h6C6B6A69, 1'b1, 1'b0, 5},
      '{1'b1, 1'b0, 32'h6D6C6B6A, 1'b1, 1'b0, 6},
      '{1'b1, 1'b0, 32'h6E6D6C6B, 1'b1, 1'b0, 7},
      '{1'b1, 1'b0, 32'h6F6E6D6C, 1'b1, 1'b0, 8},
      '{1'b1, 1'b0, 32'h706F6E6D, 1'b1, 1'b0, 9},
      '{1'b1, 1'b0, 32'h71706F6E, 1'b0, 1'b1, 10},
      '{1'b1, 1'b0, 32'h7271706F, 1'b0, 1'b1, 10}
    };

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_in_data = '0;
    lasta = '0; lastb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_b_out_valid", s_out_valid, 0);
    rst = 1'b1;

    // Unstalled stream of 20 beats
    sent = 0; got = 0; first_acc = -1; first_ov = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (sent < 20);
      in_data  = pack4(sent);
      cyc();
      if (in_valid && obs_irdy) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (obs_ovld) begin
        if (first_ov < 0) first_ov = c;
        chk("t1_data", obs_odata, pack4(got));
        got++;
      end
      if (first_acc >= 0 && c == first_acc + 10) chk("t1_occ_steady", obs_occ, 10);
    end
    in_valid = 1'b0;
    chk("t1_latency", first_ov - first_acc, 10);
    chk("t1_count", got, 20);

    // Fill against a stalled output
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid  = tbl[i].iv;
      out_ready = tbl[i].ordy;
      in_data   = tbl[i].d;
      cyc();
      chk("t2_in_ready", obs_irdy, tbl[i].e_irdy);
      chk("t2_out_valid", obs_ovld, tbl[i].e_ovld);
      chk("t2_occupancy", obs_occ, tbl[i].e_occ);
      if (in_valid && obs_irdy) acc++;
    end
    chk("t2_accepted", acc, 10);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 11; j++) begin
      cyc();
      chk("t2_drain_valid", obs_ovld, (j < 10));
      if (j < 10) chk("t2_drain_data", obs_odata, pack4(100 + j));
    end

    // Sparse input, then output stall collapses the bubbles
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = pack4(200 + c / 2);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (5) cyc();
    chk("t3_occ_stall", obs_occ, 5);
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cyc();
      chk("t3_valid", obs_ovld, (j < 5));
      if (j < 5) chk("t3_data", obs_odata, pack4(200 + j));
    end

    // Flush with 7 beats in flight
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = pack4(50 + i);
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("t4_pre_valid", obs_ovld, 1);
    chk("t4_pre_occ", obs_occ, 7);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = pack4(60);
    cyc();
    chk("t4_flush_in_ready", obs_irdy, 0);
    chk("t4_flush_out_valid", obs_ovld, 0);
    flush = 1'b0; in_valid = 1'b0;
    cyc();
    chk("t4_post_occ", obs_occ, 0);
    chk("t4_post_valid", obs_ovld, 0);
    in_valid = 1'b1; in_data = pack4(77);
    cyc();
    chk("t4_new_accept", obs_irdy, 1);
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c < 16; c++) begin
      cyc();
      if (obs_ovld && lat < 0) begin
        lat = c;
        chk("t4_new_data", obs_odata, pack4(77));
      end
    end
    chk("t4_new_latency", lat, 10);

    // Asynchronous reset between clock edges
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = pack4(30 + i);
      cyc();
    end
    in_valid = 1'b0;
    repeat (8) cyc();
    chk("t5_pre_valid", obs_ovld, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_out_data", out_data, 0);
    chk("t5_rst_occupancy", occupancy, 0);
    qa.delete(); qb.delete(); lasta = '0; lastb = '0;
    @(posedge clk);
    #1;
    rst = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      cyc();
      chk("t5_no_stale", obs_ovld, 0);
    end

    // Random traffic on both instances
    for (int c = 0; c < 400; c++) begin
      flush       = ($urandom_range(0, 29) == 0);
      in_valid    = ($urandom_range(0, 1) == 1);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_data     = $urandom;
      s_flush     = ($urandom_range(0, 29) == 0);
      s_in_valid  = ($urandom_range(0, 1) == 1);
      s_out_ready = ($urandom_range(0, 1) == 1);
      s_in_data   = 16'($urandom);
      cyc();
    end
    flush = 1'b0; s_flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
